// File: rtl/scan_drv_pkg.sv
// Shared types and constants for the scan chain driver and its optional MISR.
package scan_drv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADED  = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [31:0] MISR_POLY  = 32'h04C11DB7;
    localparam logic        SHIFT_FILL = 1'b0;

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic d);
        return {s[30:0], s[31]} ^ (s[31] ? MISR_POLY : 32'h0) ^ {31'b0, d};
    endfunction

endpackage

// File: rtl/scan_drv_misr.sv
// 32-bit MISR folding the observed scan-out stream; used only when SCAN_DRV_MISR_EN is defined.
module scan_drv_misr
    import scan_drv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [31:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/scan_chain_driver.sv
// Tester-side scan chain driver: serial load with overlapped unload, one capture pulse per pattern.
// Optional SIG output (MISR over observed responses) is enabled by defining SCAN_DRV_MISR_EN.
module scan_chain_driver
    import scan_drv_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CP,
    input  logic                 CD,
    input  logic [CHAIN_LEN-1:0] PAT_DATA,
    input  logic                 PAT_LAST,
    input  logic                 PAT_VALID,
    output logic                 PAT_READY,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic [CHAIN_LEN-1:0] RSP_DATA,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic                 BUSY
`ifdef SCAN_DRV_MISR_EN
    ,
    output logic [31:0]          SIG
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat_sh;
    logic [CHAIN_LEN-1:0] rsp_sh;
    logic [CHAIN_LEN-1:0] rsp_data;
    logic [CHAIN_LEN-1:0] rsp_word;
    logic                 last_q;
    logic                 unload_only;
    logic                 cap_flag;
    logic                 pat_ready;
    logic                 rsp_valid;
    logic                 se;
    logic                 si;
    logic                 accept;
    logic                 rsp_hold;
    logic                 start_unload;

    assign accept   = PAT_VALID & pat_ready;
    assign rsp_hold = rsp_valid & ~RSP_READY;
    assign rsp_word = {rsp_sh[CHAIN_LEN-2:0], SO};
    // The final unload waits in LOADED while an earlier response is still unclaimed.
    assign start_unload = last_q & ~rsp_hold & ((state == CAPTURE) | (state == LOADED));

    always_ff @(posedge CP) begin
        if (CD) begin
            state       <= IDLE;
            cnt         <= '0;
            last_q      <= 1'b0;
            unload_only <= 1'b0;
            cap_flag    <= 1'b0;
            pat_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            se          <= 1'b0;
            si          <= 1'b0;
        end else begin
            rsp_valid <= rsp_hold;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SHIFT;
                        se          <= 1'b1;
                        si          <= PAT_DATA[CHAIN_LEN-1];
                        last_q      <= PAT_LAST;
                        unload_only <= 1'b0;
                        cnt         <= '0;
                        pat_ready   <= 1'b0;
                    end else begin
                        pat_ready <= ~rsp_hold;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST_CNT) begin
                        cnt <= cnt + CNT_W'(1);
                        si  <= pat_sh[CHAIN_LEN-1];
                    end else begin
                        se  <= 1'b0;
                        si  <= 1'b0;
                        cnt <= '0;
                        if (cap_flag) begin
                            rsp_data  <= rsp_word;
                            rsp_valid <= 1'b1;
                        end
                        if (unload_only) begin
                            state     <= IDLE;
                            cap_flag  <= 1'b0;
                            pat_ready <= ~cap_flag & ~rsp_hold;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    cap_flag <= 1'b1;
                    if (start_unload) begin
                        state       <= SHIFT;
                        unload_only <= 1'b1;
                        se          <= 1'b1;
                        si          <= SHIFT_FILL;
                    end else begin
                        state     <= LOADED;
                        pat_ready <= ~last_q & ~rsp_hold;
                    end
                end
                LOADED: begin
                    if (start_unload) begin
                        state       <= SHIFT;
                        unload_only <= 1'b1;
                        se          <= 1'b1;
                        si          <= SHIFT_FILL;
                        pat_ready   <= 1'b0;
                    end else if (accept) begin
                        state       <= SHIFT;
                        se          <= 1'b1;
                        si          <= PAT_DATA[CHAIN_LEN-1];
                        last_q      <= PAT_LAST;
                        unload_only <= 1'b0;
                        cnt         <= '0;
                        pat_ready   <= 1'b0;
                    end else begin
                        pat_ready <= ~last_q & ~rsp_hold;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pattern and response shifters carry data only and need no reset.
    always_ff @(posedge CP) begin
        if (accept) begin
            pat_sh <= {PAT_DATA[CHAIN_LEN-2:0], SHIFT_FILL};
        end else if (start_unload) begin
            pat_sh <= {CHAIN_LEN{SHIFT_FILL}};
        end else if (state == SHIFT) begin
            pat_sh <= {pat_sh[CHAIN_LEN-2:0], SHIFT_FILL};
        end
        if (state == SHIFT) begin
            rsp_sh <= rsp_word;
        end
    end

`ifdef SCAN_DRV_MISR_EN
    scan_drv_misr u_misr (
        .clk (CP),
        .rst (CD),
        .clr (accept && (state == IDLE)),
        .en  ((state == SHIFT) && cap_flag),
        .din (SO),
        .sig (SIG)
    );
`endif

    assign PAT_READY = pat_ready;
    assign SE        = se;
    assign SI        = si;
    assign RSP_DATA  = rsp_data;
    assign RSP_VALID = rsp_valid;
    assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver with an 8-cell chain model that inverts its contents on capture.
module tb_scan_chain_driver;

    localparam int L = 8;

    typedef struct packed {
        logic [L-1:0] pat;
        logic         last;
        logic [L-1:0] exp;
    } vec_t;

    logic         CP = 1'b0;
    logic         CD = 1'b1;
    logic [L-1:0] PAT_DATA = '0;
    logic         PAT_LAST = 1'b0;
    logic         PAT_VALID = 1'b0;
    logic         PAT_READY;
    logic         SE;
    logic         SI;
    logic         SO;
    logic [L-1:0] RSP_DATA;
    logic         RSP_VALID;
    logic         RSP_READY = 1'b1;
    logic         BUSY;
`ifdef SCAN_DRV_MISR_EN
    logic [31:0]  SIG;
`endif

    int checks = 0;
    int errors = 0;
    int n_push = 0;
    int n_rsp  = 0;
    int se_run = 0;
    logic [L-1:0] exp_q[$];
    logic [L-1:0] popped;

    logic [L-1:0] chain = 8'h3C;
    logic         se_d  = 1'b0;

    scan_chain_driver #(.CHAIN_LEN(L)) dut (
        .CP        (CP),
        .CD        (CD),
        .PAT_DATA  (PAT_DATA),
        .PAT_LAST  (PAT_LAST),
        .PAT_VALID (PAT_VALID),
        .PAT_READY (PAT_READY),
        .SE        (SE),
        .SI        (SI),
        .SO        (SO),
        .RSP_DATA  (RSP_DATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .BUSY      (BUSY)
`ifdef SCAN_DRV_MISR_EN
        ,
        .SIG       (SIG)
`endif
    );

    always #5 CP = ~CP;

    // Chain model: shifts with SE, captures (inverted) on the first SE-low cycle after a shift.
    assign SO = chain[L-1];
    always @(posedge CP) begin
        se_d <= SE;
        if (SE) chain <= {chain[L-2:0], SI};
        else if (BUSY && se_d) chain <= ~chain;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] misr_model(input logic [L-1:0] r);
        logic [31:0] s;
        s = '0;
        for (int b = L - 1; b >= 0; b--) begin
            s = {s[30:0], s[31]} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {31'b0, r[b]};
        end
        return s;
    endfunction

    // Response scoreboard and shift-run length monitor.
    always @(negedge CP) begin
        if (!CD && RSP_VALID && RSP_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %0h, no response was due", RSP_DATA);
            end else begin
                popped = exp_q.pop_front();
                n_rsp++;
                check("rsp_data", 32'(RSP_DATA), 32'(popped));
            end
        end
        if (SE) begin
            se_run++;
        end else if (se_run != 0) begin
            if (!CD) check("se_run_len", se_run, L);
            se_run = 0;
        end
    end

    task automatic expect_rsp(input logic [L-1:0] r);
        exp_q.push_back(r);
        n_push++;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [L-1:0] pat, input logic last);
        int n;
        PAT_DATA  = pat;
        PAT_LAST  = last;
        PAT_VALID = 1'b1;
        n = 0;
        while (!PAT_READY && n < 300) begin
            @(negedge CP);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: PAT_READY got 0 for %0d cycles, expected 1", n);
        end else begin
            @(negedge CP);
        end
        PAT_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(!BUSY && !RSP_VALID && exp_q.size() == 0) && n < 400) begin
            @(negedge CP);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: BUSY=%0b RSP_VALID=%0b pending=%0d, expected idle", BUSY, RSP_VALID, exp_q.size());
        end
        @(negedge CP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[6];
        int           c;
        int           hold_ok;
        logic [L-1:0] si_seq;
        logic [L-1:0] held;
        logic         se_ok;

        vt[0] = '{pat: 8'h0F, last: 1'b0, exp: 8'hF0};
        vt[1] = '{pat: 8'hF0, last: 1'b1, exp: 8'h0F};
        vt[2] = '{pat: 8'h33, last: 1'b0, exp: 8'hCC};
        vt[3] = '{pat: 8'hC3, last: 1'b0, exp: 8'h3C};
        vt[4] = '{pat: 8'hE7, last: 1'b1, exp: 8'h18};
        vt[5] = '{pat: 8'h80, last: 1'b1, exp: 8'h7F};

        repeat (2) @(posedge CP);
        @(negedge CP);
        check("rst_se", SE, 0);
        check("rst_si", SI, 0);
        check("rst_pat_ready", PAT_READY, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_data", 32'(RSP_DATA), 0);
        check("rst_busy", BUSY, 0);
        @(posedge CP);
        #1 CD = 1'b0;
        @(negedge CP);

        // Single pattern: load, capture, unload, one response 2*L+1 cycles after accept.
        expect_rsp(8'h5A);
        send(8'hA5, 1'b1);
        c = 0;
        while (!RSP_VALID && c < 100) begin
            @(negedge CP);
            c++;
        end
        check("single_latency", c, 2 * L + 1);
        check("single_idle", BUSY, 0);
        wait_idle();

        // SI ordering: MSB first, so bit 0 appears only in the last shift cycle.
        expect_rsp(8'hFE);
        send(8'h01, 1'b1);
        si_seq = '0;
        se_ok  = 1'b1;
        for (int k = 0; k < L; k++) begin
            si_seq = {si_seq[L-2:0], SI};
            se_ok  = se_ok & SE;
            if (k < L - 1) @(negedge CP);
        end
        check("si_order", 32'(si_seq), 32'h01);
        check("se_during_shift", se_ok, 1);
        @(negedge CP);
        check("chain_loaded", 32'(chain), 32'h01);
        wait_idle();

        // Table of pattern sets offered back to back.
        for (int i = 0; i < 6; i++) begin
            expect_rsp(vt[i].exp);
            send(vt[i].pat, vt[i].last);
        end
        wait_idle();

        // Backpressure on the first response of a two-pattern set.
        @(posedge CP);
        #1 RSP_READY = 1'b0;
        @(negedge CP);
        expect_rsp(8'hCC);
        send(8'h33, 1'b0);
        expect_rsp(8'h3C);
        send(8'hC3, 1'b1);
        c = 0;
        while (!RSP_VALID && c < 100) begin
            @(negedge CP);
            c++;
        end
        check("bp_rsp_arrive", RSP_VALID, 1);
        held    = RSP_DATA;
        hold_ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (!PAT_READY && RSP_VALID && RSP_DATA == held && BUSY && !SE) hold_ok++;
            @(negedge CP);
        end
        check("bp_hold_cycles", hold_ok, 20);
        check("bp_first_data", 32'(held), 32'hCC);
        @(posedge CP);
        #1 RSP_READY = 1'b1;
        wait_idle();

        // Reset in the third shift cycle aborts without a response.
        send(8'h5C, 1'b1);
        @(negedge CP);
        @(negedge CP);
        CD = 1'b1;
        @(negedge CP);
        check("abort_se", SE, 0);
        check("abort_busy", BUSY, 0);
        check("abort_rsp_valid", RSP_VALID, 0);
        @(posedge CP);
        #1 CD = 1'b0;
        @(negedge CP);
        expect_rsp(8'h69);
        send(8'h96, 1'b1);
        wait_idle();

`ifdef SCAN_DRV_MISR_EN
        for (int i = 0; i < 3; i++) begin
            expect_rsp(8'h00);
            send(8'hFF, (i == 2));
        end
        wait_idle();
        check("misr_zero", SIG, 32'h0);
        expect_rsp(8'h01);
        send(8'hFE, 1'b1);
        wait_idle();
        check("misr_one", SIG, misr_model(8'h01));
`endif

        check("rsp_count", n_rsp, n_push);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
